seq_detect_param: RTL

Parametrised, runtime-programmable serial sequence detector; next generation of the fixed 4-bit Mealy "0100" detector. Samples one serial bit per qualified clock, compares the most recent `cfg_len` bits against a loadable pattern, and emits a registered one-cycle `match` pulse. Supports overlapping and non-overlapping detection and an optional saturating match counter. Sits on serial receive paths (framing/sync-word search) between the bit recoverer and the frame aligner.

---
 rtl/seq_detect_param.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-programmable serial sequence detector.
// Compares the newest len accepted bits against a loadable pattern and
// emits a registered one-cycle match pulse (overlapping or non-overlapping).
// Optional feature macro: SEQDET_MATCH_COUNT_EN enables the saturating
// match_count register; without it match_count is tied to zero.
module seq_detect_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_0100,
  parameter int                 DEF_LEN     = 4,
  parameter int                 CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               match,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] MAX_LEN_C  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] DEF_LEN_C  = LEN_W'(DEF_LEN);
  localparam logic [LEN_W-1:0] LEN_ZERO_C = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE_C  = {{(LEN_W-1){1'b0}}, 1'b1};

  // Active configuration and history
  logic [MAX_LEN-1:0] hist_r, hist_s, shift_s;
  logic [LEN_W-1:0]   fill_r, fill_s, fill_inc_s;
  logic [MAX_LEN-1:0] pat_r, pat_s;
  logic [LEN_W-1:0]   len_r, len_s;
  logic               ovl_r, ovl_s;
  logic               match_r, match_s;
  logic               cfg_err_r, cfg_err_s;
  logic [MAX_LEN-1:0] mask_s;
  logic               legal_s, hit_s;

  // Build a mask covering the len_r newest history positions
  always_comb begin
    mask_s = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < len_r) begin
        mask_s[i] = 1'b1;
      end else begin
        mask_s[i] = 1'b0;
      end
    end
  end

  // Candidate history/fill for an accepted bit and the resulting hit decision
  always_comb begin
    legal_s    = (cfg_len != LEN_ZERO_C) && (cfg_len <= MAX_LEN_C);
    shift_s    = {hist_r[MAX_LEN-2:0], din};
    if (fill_r >= MAX_LEN_C) begin
      fill_inc_s = fill_r;
    end else begin
      fill_inc_s = fill_r + LEN_ONE_C;
    end
    hit_s = (fill_inc_s >= len_r) &&
            (((shift_s ^ pat_r) & mask_s) == {MAX_LEN{1'b0}});
  end

  // Next-state selection: configuration load has priority over data bits
  always_comb begin
    hist_s    = hist_r;
    fill_s    = fill_r;
    pat_s     = pat_r;
    len_s     = len_r;
    ovl_s     = ovl_r;
    match_s   = 1'b0;
    cfg_err_s = cfg_err_r;
    if (cfg_load) begin
      if (legal_s) begin
        pat_s     = cfg_pattern;
        len_s     = cfg_len;
        ovl_s     = cfg_overlap;
        fill_s    = LEN_ZERO_C;
        cfg_err_s = 1'b0;
      end else begin
        cfg_err_s = 1'b1;
      end
    end else if (din_valid) begin
      hist_s = shift_s;
      if (hit_s) begin
        match_s = 1'b1;
        // Non-overlapping mode restarts the fill so the next match needs len fresh bits
        if (ovl_r) begin
          fill_s = fill_inc_s;
        end else begin
          fill_s = LEN_ZERO_C;
        end
      end else begin
        fill_s = fill_inc_s;
      end
    end else begin
      match_s = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_r    <= {MAX_LEN{1'b0}};
      fill_r    <= LEN_ZERO_C;
      pat_r     <= DEF_PATTERN;
      len_r     <= DEF_LEN_C;
      ovl_r     <= 1'b1;
      match_r   <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      hist_r    <= hist_s;
      fill_r    <= fill_s;
      pat_r     <= pat_s;
      len_r     <= len_s;
      ovl_r     <= ovl_s;
      match_r   <= match_s;
      cfg_err_r <= cfg_err_s;
    end
  end

  assign match   = match_r;
  assign cfg_err = cfg_err_r;

`ifdef SEQDET_MATCH_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;
  logic             cnt_clr_s, cnt_inc_s;

  assign cnt_clr_s = cfg_load & legal_s;
  assign cnt_inc_s = ~cfg_load & din_valid & hit_s;

  // Saturating match counter, cleared by each legal reconfiguration
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_inc_s && (cnt_r != CNT_MAX_C)) begin
      cnt_r <= cnt_r + CNT_ONE_C;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign match_count = cnt_r;
`else
  assign match_count = {CNT_W{1'b0}};
`endif

endmodule
